uart_tx_fifo: RTL and testbench

UART transmitter with a small input FIFO. It is the upstream stage that drives the serial line sampled by the UART receiver. Parallel bytes arrive over a valid/ready handshake, are buffered, and leave as 8N1 frames, LSB first, at CLOCKS_PER_PULSE clocks per bit. The bit timing matches the receiver's parameter, so both ends of a loopback share one CLOCKS_PER_PULSE value.

---
 rtl/uart_tx_fifo_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
//   data_in    : byte offered by the producer
//   data_valid : data_in is valid this cycle
//   data_ready : transmitter FIFO can accept a byte this cycle
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset (aborts frame, empties FIFO)
//   bus        : byte handshake (uart_tx_fifo_if.slave)
//   tx         : registered serial line, idle high
//   busy       : frame in progress or bytes buffered
//   fifo_count : bytes currently buffered
//
// state     | meaning
// ----------+------------------------------------------------
// TX_IDLE   | line high, waiting for a buffered byte
// TX_START  | start bit (low)
// TX_DATA   | 8 data bits, LSB first
// TX_PARITY | even parity bit (only with UART_TX_PARITY_EN)
// TX_STOP   | stop bit (high); chains straight into next start
module uart_tx_fifo #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 bus,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW   = $clog2(CLOCKS_PER_PULSE);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic push, pop, last_clk;

  // Readiness is based on the current count only, so a full FIFO refuses a
  // push even on the edge that pops.
  assign bus.data_ready = (count_q < CNTW'(FIFO_DEPTH));
  assign push           = bus.data_valid && bus.data_ready;
  assign last_clk       = (clk_cnt_q == CW'(CLOCKS_PER_PULSE - 1));

  assign tx         = tx_q;
  assign busy       = (state_q != TX_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != TX_IDLE)
      clk_cnt_d = last_clk ? '0 : clk_cnt_q + CW'(1);

    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          state_d   = TX_START;
          clk_cnt_d = '0;
          tx_d      = 1'b0;
        end
      end
      TX_START: begin
        if (last_clk) begin
          state_d   = TX_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      TX_DATA: begin
        if (last_clk) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = parity_q;
`else
            state_d = TX_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (last_clk) begin
          state_d = TX_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (last_clk) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = TX_START;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: begin
        state_d   = TX_IDLE;
        clk_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase

    // The popped byte moves into the shift register, so later pushes that
    // reuse this FIFO slot cannot disturb the frame in flight.
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.data_in;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CPP   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       rst;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.CLOCKS_PER_PULSE(CPP), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one byte for exactly one edge; called at a negedge, returns at the next.
  task automatic push(input logic [7:0] b);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  // Returns at the negedge right after the edge where tx fell.
  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (tx === 1'b0) break;
      n++;
    end
    if (n >= 400) check({tag, "_fall_timeout"}, 32'd1, 32'd0);
  endtask

  // Entered at the negedge after the falling edge F. Checks first and last
  // cycle of every bit; returns at the negedge after F + 16*FB - 1.
  task automatic recv(input logic [7:0] b, input string tag);
    logic [10:0] fr;
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, ^b, b, 1'b0};
`else
    fr = {1'b0, 1'b1, b, 1'b0};
`endif
    for (int k = 0; k < FB; k++) begin
      check($sformatf("%s_bit%0d_first", tag, k), {31'd0, tx}, {31'd0, fr[k]});
      repeat (CPP - 1) @(negedge clk);
      check($sformatf("%s_bit%0d_last", tag, k), {31'd0, tx}, {31'd0, fr[k]});
      if (k < FB - 1) @(negedge clk);
    end
  endtask

  logic [7:0] t4_data [8];
  logic       t4_ready [8];

  initial begin
    rst            = 1'b1;
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    repeat (50) @(negedge clk);
    check("idle_tx",    {31'd0, tx},             32'd1);
    check("idle_busy",  {31'd0, busy},           32'd0);
    check("idle_count", {29'd0, fifo_count},     32'd0);
    check("idle_ready", {31'd0, bus.data_ready}, 32'd1);

    // 2: single byte, one-cycle latency, exact bit widths, busy release
    push(8'hA3);
    check("a3_tx_at_push",    {31'd0, tx},         32'd1);
    check("a3_count_at_push", {29'd0, fifo_count}, 32'd1);
    @(negedge clk);
    check("a3_tx_fell",      {31'd0, tx},         32'd0);
    check("a3_count_popped", {29'd0, fifo_count}, 32'd0);
    recv(8'hA3, "a3");
    check("a3_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("a3_busy_done", {31'd0, busy}, 32'd0);
    check("a3_tx_idle",   {31'd0, tx},   32'd1);
    repeat (5) @(negedge clk);

    // 3: three back-to-back frames with no gap
    fork
      begin push(8'h55); push(8'h0F); push(8'hF0); end
      begin
        wait_fall("b2b");
        recv(8'h55, "b2b0"); @(negedge clk);
        recv(8'h0F, "b2b1"); @(negedge clk);
        recv(8'hF0, "b2b2");
      end
    join
    check("b2b_busy_last", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("b2b_busy_done", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // 4: valid held for 8 bytes; first pops at once, four more fill the FIFO
    for (int i = 0; i < 8; i++) begin
      t4_data[i]  = 8'(i + 1);
      t4_ready[i] = (i < 5);
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          bus.data_in    = t4_data[i];
          bus.data_valid = 1'b1;
          check($sformatf("flood_ready%0d", i), {31'd0, bus.data_ready}, {31'd0, t4_ready[i]});
          @(negedge clk);
        end
        bus.data_valid = 1'b0;
        check("flood_count", {29'd0, fifo_count},     32'd4);
        check("flood_full",  {31'd0, bus.data_ready}, 32'd0);
      end
      begin
        wait_fall("flood");
        for (int i = 0; i < 5; i++) begin
          recv(t4_data[i], $sformatf("flood%0d", i));
          @(negedge clk);
        end
      end
    join
    check("flood_busy_done", {31'd0, busy}, 32'd0);
    check("flood_tx_idle",   {31'd0, tx},   32'd1);
    repeat (5) @(negedge clk);

    // 5: reset in the middle of data bit 3 of 0x3C with two bytes queued
    fork
      begin push(8'h3C); push(8'h11); push(8'h22); end
      begin
        wait_fall("rst");
        repeat (CPP * 4 + 8) @(negedge clk);
        check("rst_mid_bit3", {31'd0, tx},         32'd1);
        check("rst_queued",   {29'd0, fifo_count}, 32'd2);
      end
    join
    rst = 1'b1;
    #1;
    check("rst_tx",    {31'd0, tx},         32'd1);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_after_tx", {31'd0, tx}, 32'd1);
    push(8'h81);
    @(negedge clk);
    check("x81_fell", {31'd0, tx}, 32'd0);
    recv(8'h81, "x81");
    @(negedge clk);
    check("x81_busy_done", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // 6: parity-bearing or plain frame, depending on build
`ifdef UART_TX_PARITY_EN
    push(8'h07);
    @(negedge clk);
    check("x07_fell", {31'd0, tx}, 32'd0);
    recv(8'h07, "x07");
    @(negedge clk);
    check("x07_busy_done", {31'd0, busy}, 32'd0);
`else
    push(8'h5A);
    @(negedge clk);
    check("x5a_fell", {31'd0, tx}, 32'd0);
    recv(8'h5A, "x5a");
    @(negedge clk);
    check("x5a_busy_done", {31'd0, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
